// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, exponent bias and the packed result layout.
package fp32_pkg;

    localparam int FP32_BIAS   = 127;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Leading-zero count of a 32-bit word; count is 0 (unused) when all_zero is set.
// Latency: combinational.
// Backpressure: none, pure function of data.
module lzc32 (
    input  logic [31:0] data,
    output logic [4:0]  count,
    output logic        all_zero
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (data[i]) begin
                count = 5'(31 - i);
            end
        end
    end

    assign all_zero = (data == 32'd0);

endmodule

// File: rtl/int_to_fp32.sv
// Integer to binary32 converter; two's complement input when INT_TO_FP32_SIGNED_EN is defined.
// Latency: 3 cycles (S1 sign/magnitude, S2 normalise, S3 round/pack), one result per cycle.
// Backpressure: valid/ready; a stalled output holds, upstream stages fill, then i_ready drops.
module int_to_fp32
    import fp32_pkg::*;
#(
    parameter int ROUND_NEAREST = 1
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_int,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_f32
);

    logic        rdy_en;
    logic        s1_vld;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic        s2_vld;
    logic        s2_sign;
    logic        s2_zero;
    logic [4:0]  s2_pos;
    logic [31:0] s2_norm;

    logic        in_sign;
    logic [31:0] in_mag;
    logic [4:0]  lz_cnt;
    logic        lz_zero;
    logic        s3_load;
    logic        s2_load;

    // Each stage may load when empty or when its occupant moves on this cycle.
    assign s3_load = !o_valid || o_ready;
    assign s2_load = !s2_vld || s3_load;
    assign i_ready = rdy_en && (!s1_vld || s2_load);

`ifdef INT_TO_FP32_SIGNED_EN
    assign in_sign = i_int[31];
    assign in_mag  = i_int[31] ? (~i_int + 32'd1) : i_int;
`else
    assign in_sign = 1'b0;
    assign in_mag  = i_int;
`endif

    lzc32 u_lzc (
        .data     (s1_mag),
        .count    (lz_cnt),
        .all_zero (lz_zero)
    );

    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        round_up;
    logic [24:0] sig_rnd;
    fp32_t       res;

    // After normalisation the leading one sits at bit 31; frac is [30:8], guard is bit 7.
    always_comb begin
        guard    = s2_norm[7];
        sticky   = |s2_norm[6:0];
        lsb      = s2_norm[8];
        round_up = (ROUND_NEAREST != 0) && guard && (sticky || lsb);
        sig_rnd  = {1'b0, s2_norm[31:8]} + {24'd0, round_up};
        res.sign = s2_sign;
        res.exp  = FP32_EXP_W'(FP32_BIAS) + {3'd0, s2_pos} + {7'd0, sig_rnd[24]};
        res.frac = sig_rnd[24] ? '0 : sig_rnd[FP32_FRAC_W-1:0];
        if (s2_zero) begin
            res = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            rdy_en  <= 1'b0;
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_pos  <= '0;
            s2_norm <= '0;
            o_valid <= 1'b0;
            o_f32   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (i_ready) begin
                s1_vld <= i_valid;
                if (i_valid) begin
                    s1_sign <= in_sign;
                    s1_mag  <= in_mag;
                end
            end
            if (s2_load) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_sign <= s1_sign;
                    s2_zero <= lz_zero;
                    s2_pos  <= 5'd31 - lz_cnt;
                    s2_norm <= s1_mag << lz_cnt;
                end
            end
            if (s3_load) begin
                o_valid <= s2_vld;
                if (s2_vld) begin
                    o_f32 <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp32.sv
// Scoreboard bench: RNE instance (a) and truncating instance (b) share stimulus and o_ready.
module tb_int_to_fp32;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready = 1'b1;
    logic [31:0] i_int = '0;
    logic        i_ready_a, o_valid_a, i_ready_b, o_valid_b;
    logic [31:0] o_f32_a, o_f32_b;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] f;
        int          t;
        bit          lat;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;
    bit          lat_chk = 1'b0;

    logic [31:0] small_exp [10] = '{
        32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000
    };
    logic [31:0] bp_exp [6] = '{
        32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
    };

    int_to_fp32 #(.ROUND_NEAREST(1)) dut_a (
        .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .i_ready(i_ready_a), .i_int(i_int),
        .o_valid(o_valid_a), .o_ready(o_ready), .o_f32(o_f32_a)
    );

    int_to_fp32 #(.ROUND_NEAREST(0)) dut_b (
        .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .i_ready(i_ready_b), .i_int(i_int),
        .o_valid(o_valid_b), .o_ready(o_ready), .o_f32(o_f32_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Expected results are queued at the moment the input handshake is seen.
    always @(negedge clk) begin
        if (rst_x && i_valid && i_ready_a) begin
            qa.push_back('{cur_a, cyc, lat_chk});
            qb.push_back('{cur_b, cyc, 1'b0});
        end
    end

    always @(negedge clk) begin
        if (rst_x && o_valid_a && o_ready) begin
            if (qa.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out_a: got %h, expected no output", o_f32_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("result_rne", o_f32_a, e.f);
                if (e.lat) check("latency_rne", 32'(cyc - e.t), 32'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_x && o_valid_b && o_ready) begin
            if (qb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out_trunc: got %h, expected no output", o_f32_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("result_trunc", o_f32_b, e.f);
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [31:0] ea, input logic [31:0] eb);
        int budget;
        budget = 0;
        i_valid = 1'b1;
        i_int   = v;
        cur_a   = ea;
        cur_b   = eb;
        @(negedge clk);
        while (!i_ready_a && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!i_ready_a) begin
            n_chk++;
            $display("FAIL send_timeout: i_ready stuck at 0, input %h", v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((qa.size() != 0 || qb.size() != 0) && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", qa.size(), qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        bit          have;

        repeat (2) @(negedge clk);
        check("rst_o_valid", 32'(o_valid_a), 32'd0);
        check("rst_o_f32", o_f32_a, 32'd0);
        check("rst_i_ready", 32'(i_ready_a), 32'd0);
        @(posedge clk);
        #1 rst_x = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 32'(i_ready_a), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(i_ready_a), 32'd1);
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) send(32'(i), small_exp[i], small_exp[i]);
        i_valid = 1'b0;
        lat_chk = 1'b0;
        drain();

        send(32'd16777217, 32'h4B800000, 32'h4B800000);
        send(32'd16777219, 32'h4B800002, 32'h4B800001);
`ifdef INT_TO_FP32_SIGNED_EN
        send(32'hFFFFFFFF, 32'hBF800000, 32'hBF800000);
        send(32'h80000000, 32'hCF000000, 32'hCF000000);
        send(32'hFFFFFFF7, 32'hC1100000, 32'hC1100000);
`else
        send(32'hFFFFFFFF, 32'h4F800000, 32'h4F7FFFFF);
        send(32'h80000000, 32'h4F000000, 32'h4F000000);
        send(32'hFFFFFFF7, 32'h4F800000, 32'h4F7FFFFF);
`endif
        i_valid = 1'b0;
        drain();

        held = '0;
        have = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'(10 + i), bp_exp[i], bp_exp[i]);
                i_valid = 1'b0;
            end
            begin
                o_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (o_valid_a) begin
                        if (!have) begin
                            held = o_f32_a;
                            have = 1'b1;
                        end else begin
                            check("stall_hold", o_f32_a, held);
                        end
                    end
                end
                check("stall_o_valid", 32'(o_valid_a), 32'd1);
                check("stall_head", o_f32_a, bp_exp[0]);
                check("stall_i_ready_rne", 32'(i_ready_a), 32'd0);
                check("stall_i_ready_trunc", 32'(i_ready_b), 32'd0);
                @(posedge clk);
                #1 o_ready = 1'b1;
            end
        join
        drain();

        send(32'd5, 32'h40A00000, 32'h40A00000);
        send(32'd6, 32'h40C00000, 32'h40C00000);
        i_valid = 1'b0;
        @(posedge clk);
        #1 rst_x = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check("midrst_o_valid", 32'(o_valid_a), 32'd0);
        check("midrst_o_f32", o_f32_a, 32'd0);
        check("midrst_i_ready", 32'(i_ready_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_x = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", 32'(o_valid_a), 32'd0);
        check("post_rst_ready", 32'(i_ready_b), 32'd1);
        @(posedge clk);
        #1;
        send(32'd7, 32'h40E00000, 32'h40E00000);
        i_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/int_to_fp32.md
INT_TO_FP32 -- requirements
Module: int_to_fp32

Interface
- REQ-001: Parameter ROUND_NEAREST, default 1; 1 = round-to-nearest-even, 0 = truncate toward zero.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_x  input  1  reset, asynchronous, active-low.
- REQ-004: i_valid  input  1  i_int holds a conversion request.
- REQ-005: i_ready  output  1  block accepts i_int this cycle.
- REQ-006: i_int  input  32  integer to convert.
- REQ-007: o_valid  output  1  o_f32 holds a result.
- REQ-008: o_ready  input  1  downstream (mod_top i_in feeder) accepts o_f32.
- REQ-009: o_f32  output  32  IEEE-754 binary32 result: sign[31], exp[30:23], frac[22:0].

Function
- REQ-010: Input transfer occurs when i_valid && i_ready; output transfer occurs when o_valid && o_ready.
- REQ-011: Three register stages. S1 captures sign and magnitude. S2 performs leading-one detect and left-normalise. S3 rounds, adjusts the exponent and packs o_f32.
- REQ-012: Latency is exactly 3 cycles from input transfer to o_valid when o_ready is held high; throughput is one result per cycle.
- REQ-013: Each stage loads when it is empty or its contents advance in the same cycle; i_ready = !S1_valid || S1_advances; no bubble is inserted under continuous flow.
- REQ-014: While o_valid && !o_ready, o_f32 and o_valid are held stable; upstream stages fill, then i_ready falls.
- REQ-015: Zero input produces 0x00000000 (+0.0), never -0.0.
- REQ-016: For nonzero magnitude M with leading one at bit p: exp = 127 + p; frac = the 23 bits below the leading one, rounded per ROUND_NEAREST.
- REQ-017: RNE uses guard = first dropped bit and sticky = OR of remaining dropped bits; round up if guard && (sticky || lsb).
- REQ-018: A rounding carry out of the 24-bit significand increments exp and clears frac.
- REQ-019: No overflow, NaN or infinity results exist; the maximum exponent reached is 159 (2^32).
- REQ-020: Results are order-preserving: outputs appear in input-transfer order; nothing is dropped or duplicated.

Reset
- REQ-021: While rst_x = 0, all stage valid flags are cleared, o_valid = 0, o_f32 = 0, and i_ready = 1 one cycle after reset release (0 during reset).
- REQ-022: Reset asserted mid-operation discards all in-flight data; no result of a pre-reset input appears after release.

Configuration
- REQ-023: Macro INT_TO_FP32_SIGNED_EN defined: i_int is two's complement; sign = i_int[31]; magnitude = |i_int|; 0x80000000 converts to 0xCF000000.
- REQ-024: Macro INT_TO_FP32_SIGNED_EN not defined: i_int is unsigned; sign is always 0; the S1 negation logic is absent.

Structure
- REQ-025: Shared package fp32_pkg holds FP32_BIAS (127), FP32_EXP_W (8), FP32_FRAC_W (23) and an fp32_t packed typedef {sign, exp, frac}.
- REQ-026: The leading-one detect is a separate combinational sub-module lzc32 with input 32-bit data, output 5-bit count and output all_zero; it is used by S2.

Verification
- REQ-027: Inputs 0..9 streamed back-to-back with o_ready = 1 -> 0x00000000, 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000, 0x41100000, each 3 cycles after its input transfer.
- REQ-028: Rounding check with ROUND_NEAREST = 1:
  - 16777217 -> 0x4B800000 (tie rounds down to even);
  - 16777219 -> 0x4B800002 (tie rounds up);
  - 0xFFFFFFFF unsigned -> 0x4F800000 (carry into exponent).
- REQ-029: Truncation check with ROUND_NEAREST = 0: 16777219 -> 0x4B800001; 0xFFFFFFFF unsigned -> 0x4F7FFFFF.
- REQ-030: Signed build (INT_TO_FP32_SIGNED_EN defined): -1 -> 0xBF800000; 0x80000000 -> 0xCF000000; -9 -> 0xC1100000.
- REQ-031: Backpressure check, with inputs streaming continuously and o_ready held 0 for 5 cycles:
  - i_ready falls after the three stages fill;
  - o_f32 stays stable while stalled;
  - after o_ready returns to 1, all results emerge in order with none lost.
- REQ-032: rst_x pulsed low with 2 results in flight -> o_valid = 0 immediately; no stale output after release; the next input 7 yields 0x40E00000.
